// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Arbitrates two requesters onto one shared, external, combinational ALU.
//   Only one operation is in flight. Each operation runs IDLE -> EXEC -> RESP.
//   In IDLE the granted requester sees its ready. Operands, opcode and id are
//   captured on the handshake. In EXEC the captured values drive the ALU. At
//   the end of EXEC the ALU outputs are captured into the response registers.
//   The response is then held until rsp_ready is seen.
//
//   Optional feature (compile-time macro):
//     ALU_ARB_RR_EN  defined   -> round-robin grant using a last-grant register
//                    undefined -> fixed priority, req0 wins whenever it is valid
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready      request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op      operands and 3-bit opcode for requester N
//   alu_srcA, alu_srcB, alu_ctrl drive the shared ALU
//   alu_result, alu_zero         same-cycle result returned by the shared ALU
//   rsp_valid / rsp_ready        response handshake
//   rsp_result, rsp_zero         captured ALU result and zero flag
//   rsp_id                       requester that owns the response
//   rsp_err                      opcode was illegal (110 or 111)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_ctrl;
    logic             r_id;
    logic             r_err;

    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_id;
    logic             r_rsp_err;

    logic             w_grant_id;
    logic             w_accept;
    logic [2:0]       w_sel_op;
    logic             w_sel_illegal;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
    // Resets to 1 so that the first contested grant goes to req0.
    logic r_last_grant;

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end
`else
    // Fixed priority: req1 is granted only when req0 is idle.
    always_comb begin
        w_grant_id = ~req0_valid;
    end
`endif

    // rst_n is included so that no ready can appear while reset is held.
    assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid) && rst_n;
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    assign w_sel_op      = w_grant_id ? req1_op : req0_op;
    assign w_sel_illegal = w_sel_op[2] && w_sel_op[1];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: state and data registers use non-blocking assignments, so every
    // always_ff sees the values from before the clock edge regardless of
    // evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment at the top of the block keeps every path
    // assigned, so no latch is inferred for w_next_state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_EXEC;
            S_EXEC:                 w_next_state = S_RESP;
            S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture and response capture
    // -------------------------------------------------------------------------
    // NOTE: every datapath register is reset. Reset values are visible on the
    // ports: the ALU drives and the response fields read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_ctrl       <= 3'b000;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= w_grant_id ? req1_a : req0_a;
                r_b    <= w_grant_id ? req1_b : req0_b;
                // Illegal opcodes drive ADD into the ALU. The result is then
                // discarded when the response is captured.
                r_ctrl <= w_sel_illegal ? 3'b000 : w_sel_op;
                r_id   <= w_grant_id;
                r_err  <= w_sel_illegal;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= r_err ? '0   : alu_result;
                r_rsp_zero   <= r_err ? 1'b1 : alu_zero;
                r_rsp_id     <= r_id;
                r_rsp_err    <= r_err;
            end
        end
    end

    // The ALU drives stay at the last captured values outside EXEC.
    assign alu_srcA   = r_a;
    assign alu_srcB   = r_b;
    assign alu_ctrl   = r_ctrl;

    // rsp_valid is decoded from the state register. It is therefore glitch-free,
    // and reset clears it immediately.
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter with WIDTH = 32. The shared ALU is modelled
//   here as combinational logic. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_srcA, alu_srcB;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_id, rsp_err;

    int n_total = 0;
    int n_bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .alu_srcA   (alu_srcA),
        .alu_srcB   (alu_srcB),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU seen by the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000: alu_result = alu_srcA + alu_srcB;
            3'b001: alu_result = alu_srcA - alu_srcB;
            3'b010: alu_result = alu_srcA & alu_srcB;
            3'b011: alu_result = alu_srcA | alu_srcB;
            3'b100: alu_result = {31'd0, ($signed(alu_srcA) < $signed(alu_srcB))};
            3'b101: alu_result = alu_srcA ^ alu_srcB;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Called at posedge+1. Issues one request and consumes the response with
    // rsp_ready = 1. Also checks the EXEC drive and the two-cycle latency.
    // Returns at posedge+1 with the DUT back in IDLE.
    task automatic run_op(input string tag, input logic id, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] exp_ctrl, input logic [31:0] exp_r,
                          input logic exp_z, input logic exp_e);
        int n;
        logic rdy;
        rsp_ready = 1'b1;
        set_req(id, 1'b1, op, a, b);
        #1;
        n = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 10) begin
            @(posedge clk); #2;
            rdy = id ? req1_ready : req0_ready;
            n++;
        end
        check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        @(posedge clk); #1;
        set_req(id, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        check({tag, "_exec_ctrl"}, {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
        check({tag, "_exec_srcA"}, alu_srcA, a);
        check({tag, "_exec_novalid"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_result"}, rsp_result, exp_r);
        check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_z});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
        check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
        @(posedge clk); #1;
        check({tag, "_rsp_clear"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic exp_id;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        #1;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        check("rst_alu_srcA", alu_srcA, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- basic ADD, latency ----------------
        run_op("add", 1'b0, 3'b000, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);

        // ---------------- legal ops ----------------
        run_op("sub_neg", 1'b1, 3'b001, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("and", 1'b0, 3'b010, 32'hF0F0_0000, 32'hFF00_FF00, 3'b010, 32'hF000_0000, 1'b0, 1'b0);
        run_op("or", 1'b1, 3'b011, 32'h0000_00F0, 32'h0000_000F, 3'b011, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("xor_zero", 1'b0, 3'b101, 32'd5, 32'd5, 3'b101, 32'd0, 1'b1, 1'b0);

        // ---------------- illegal opcodes ----------------
        run_op("ill110", 1'b0, 3'b110, 32'd3, 32'd4, 3'b000, 32'd0, 1'b1, 1'b1);
        run_op("ill111", 1'b1, 3'b111, 32'd1, 32'd1, 3'b000, 32'd0, 1'b1, 1'b1);

        // ---------------- both requesters valid continuously ----------------
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 3'b001, 32'd9, 32'd9);
        set_req(1'b1, 1'b1, 3'b101, 32'h0000_00F0, 32'h0000_000F);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!rsp_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check("both_rsp_seen", {31'd0, rsp_valid}, 32'd1);
`ifdef ALU_ARB_RR_EN
            // The previous grant was req1, so req0 gets the first grant.
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            check("both_id", {31'd0, rsp_id}, {31'd0, exp_id});
            check("both_result", rsp_result, exp_id ? 32'h0000_00FF : 32'd0);
            check("both_zero", {31'd0, rsp_zero}, exp_id ? 32'd0 : 32'd1);
            check("both_resp_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        @(posedge clk); #1;

        // ---------------- response back-pressure with SLT ----------------
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1);
        #1;
        check("slt_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
        req0_valid = 1'b1;  // must not be accepted while a response is pending
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_result", rsp_result, 32'd1);
            check("hold_id", {31'd0, rsp_id}, 32'd1);
            check("hold_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("hold_hs_noready", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        check("hold_released", {31'd0, rsp_valid}, 32'd0);
        check("idle_after_hs", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        @(posedge clk); #1;

        // ---------------- reset during EXEC ----------------
        set_req(1'b0, 1'b1, 3'b000, 32'd1, 32'd2);
        #1;
        check("abort_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("abort_srcA", alu_srcA, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_hold", {31'd0, rsp_valid}, 32'd0);
        end
        req1_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 1'b1, 3'b001, 32'd10, 32'd3, 3'b001, 32'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester N accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-007 SHALL have ports req0_op/req1_op  input  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR.
REQ-008 SHALL have ports alu_srcA, alu_srcB  output  WIDTH  and alu_ctrl  output  3  driving the shared ALU.
REQ-009 SHALL have ports alu_result  input  WIDTH  and alu_zero  input  1  returned by the shared ALU in the same cycle.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_result  output  WIDTH, rsp_zero  output  1, rsp_id  output  1 (winning requester), rsp_err  output  1 (illegal opcode).

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-012 In IDLE, reqN_ready SHALL be 1 combinationally only for the granted requester whose reqN_valid is 1; both readies 0 in EXEC and RESP.
REQ-013 On a valid&ready handshake, operands, opcode and id SHALL be registered and FSM SHALL enter EXEC next cycle.
REQ-014 In EXEC, alu_srcA/alu_srcB/alu_ctrl SHALL come from the registered copies; elsewhere they SHALL hold the last registered values (000 opcode, zeros after reset).
REQ-015 At end of EXEC, alu_result and alu_zero SHALL be captured into rsp_result/rsp_zero, rsp_valid set, FSM to RESP.
REQ-016 Latency: handshake at cycle N -> rsp_valid=1 at cycle N+2; max throughput one operation per 3 cycles.
REQ-017 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0; on rsp_valid&rsp_ready FSM SHALL return to IDLE and clear rsp_valid next cycle.
REQ-018 A new request SHALL NOT be accepted in the same cycle as the response handshake.
REQ-019 Opcodes 110/111 SHALL be accepted, drive alu_ctrl 000, return rsp_result=0, rsp_zero=1, rsp_err=1; legal opcodes SHALL give rsp_err=0.
REQ-020 reqN_valid deasserted while not ready SHALL be tolerated with no grant and no state change.

Reset
REQ-021 rst_n low SHALL immediately force FSM IDLE, req0_ready/req1_ready 0 until rst_n high, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_id 0, rsp_err 0, operand/opcode registers 0, last-grant register 1.
REQ-022 Reset asserted in EXEC or RESP SHALL abort the in-flight operation with no response issued.

Configuration
REQ-023 With ALU_ARB_RR_EN defined, grant SHALL be round-robin: with both valid, grant the requester not granted last; last-grant updates on each request handshake; first grant after reset goes to req0.
REQ-024 Without ALU_ARB_RR_EN, grant SHALL be fixed priority: req0 whenever req0_valid=1, else req1; last-grant register absent.

Verification
REQ-025 req0 ADD a=5,b=7, rsp_ready=1 -> req0_ready at N, rsp_valid at N+2, rsp_result=12, rsp_id=0, rsp_zero=0.
REQ-026 Both valid continuously, req0 SUB 9-9, req1 XOR 0xF0^0x0F -> RR: results 0 (zero=1,id=0) then 0xFF (id=1) alternating; fixed: only id=0 responses.
REQ-027 req1 SLT a=0xFFFFFFFF,b=1, rsp_ready held 0 for 4 cycles -> rsp_result=1, rsp_id=1 stable, no readies asserted, then IDLE after handshake.
REQ-028 req0 op=110 -> rsp_err=1, rsp_result=0, rsp_zero=1, alu_ctrl=000 during EXEC.
REQ-029 rst_n low during EXEC -> rsp_valid stays 0, readies 0, after release next request completes normally with correct result.
